// File: rtl/seq_pattern_tx.sv
// seq_pattern_tx - serial pattern transmitter.
//
// Loads a parallel pattern on a start request and shifts it out MSB-first,
// one bit per clock, with a valid qualifier. The pattern is emitted
// max(repeat_n,1) times, with `gap` idle cycles between emissions.
//
// Optional feature: define SEQ_TX_PARITY_EN to append one even-parity bit
// (XOR of the pattern bits) after the data bits of every emission.
//
// Ports:
//   clk        in   system clock, all logic on posedge
//   rst_n      in   asynchronous active-low reset
//   start      in   transmit request, sampled only in IDLE
//   pattern    in   [PAT_W] bits to send, MSB first
//   repeat_n   in   [CNT_W] number of emissions, 0 treated as 1
//   gap        in   [GAP_W] idle cycles between emissions, 0 = back-to-back
//   dout       out  serial data, 0 whenever dout_vld is low
//   dout_vld   out  high while dout carries a pattern (or parity) bit
//   busy       out  high from the cycle after an accepted start until the last bit ends
//   done       out  one-cycle pulse after the final bit of the final emission
//   dbg_state  out  [2] current FSM state (0 IDLE, 1 SEND, 2 GAP)
//
// Output handshake: dout is meaningful only in cycles where dout_vld=1;
// there is no backpressure, the consumer must take each bit as it appears.
// All outputs come straight from flops.
module seq_pattern_tx #(
  parameter int PAT_W = 4,
  parameter int CNT_W = 4,
  parameter int GAP_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_n,
  input  logic [GAP_W-1:0] gap,
  output logic             dout,
  output logic             dout_vld,
  output logic             busy,
  output logic             done,
  output logic [1:0]       dbg_state
);

`ifdef SEQ_TX_PARITY_EN
  localparam int EMIT_W = PAT_W + 1;
`else
  localparam int EMIT_W = PAT_W;
`endif
  localparam int BC_W = $clog2(EMIT_W);
  localparam logic [BC_W-1:0] LAST_BIT = BC_W'(EMIT_W - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  logic [1:0]        state_q,   state_d;
  logic [EMIT_W-1:0] word_q,    word_d;     // full emission, kept for reloads
  logic [EMIT_W-1:0] shreg_q,   shreg_d;    // MSB is the bit on the line
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0]  rep_q,     rep_d;      // emissions still to go after the current one
  logic [GAP_W-1:0]  gap_len_q, gap_len_d;
  logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
  logic              dout_q,    dout_d;
  logic              vld_q,     vld_d;
  logic              busy_q,    busy_d;
  logic              done_q,    done_d;

  logic [EMIT_W-1:0] emit_word;

  always_comb begin
`ifdef SEQ_TX_PARITY_EN
    emit_word = {pattern, ^pattern};
`else
    emit_word = pattern;
`endif
  end

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    shreg_d   = shreg_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;
    gap_len_d = gap_len_q;
    gap_cnt_d = gap_cnt_q;
    done_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          word_d    = emit_word;
          shreg_d   = emit_word;
          bit_cnt_d = '0;
          // repeat_n of 0 behaves like 1: nothing left after the first emission.
          rep_d     = (repeat_n == '0) ? '0 : repeat_n - CNT_W'(1);
          gap_len_d = gap;
          state_d   = S_SEND;
        end
      end

      S_SEND: begin
        if (bit_cnt_q == LAST_BIT) begin
          bit_cnt_d = '0;
          if (rep_q != '0) begin
            rep_d = rep_q - CNT_W'(1);
            if (gap_len_q != '0) begin
              state_d   = S_GAP;
              gap_cnt_d = gap_len_q - GAP_W'(1);
            end else begin
              // Back-to-back: next MSB goes out in the very next cycle.
              shreg_d = word_q;
            end
          end else begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end else begin
          shreg_d   = {shreg_q[EMIT_W-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      S_GAP: begin
        if (gap_cnt_q == '0) begin
          state_d = S_SEND;
          shreg_d = word_q;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are decoded from next state so they land in flops.
    vld_d  = (state_d == S_SEND);
    dout_d = vld_d & shreg_d[EMIT_W-1];
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      word_q    <= '0;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
      gap_len_q <= '0;
      gap_cnt_q <= '0;
      dout_q    <= 1'b0;
      vld_q     <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      word_q    <= word_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
      gap_len_q <= gap_len_d;
      gap_cnt_q <= gap_cnt_d;
      dout_q    <= dout_d;
      vld_q     <= vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign dout      = dout_q;
  assign dout_vld  = vld_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule
